led_pwm_fader: RTL and testbench
================================

# led_pwm_fader

Downstream output stage for the board LED blinker. It takes the 4-bit on/off LED pattern and drives the physical LED pins with PWM. Each pattern edge becomes a linear brightness fade-in or fade-out instead of a hard step. It runs in the same `sys_clk` domain as its source, and its outputs go straight to the LED pins.

## Interface
Parameters:
- `PWM_BITS`, default 8: PWM counter width. PWM period is 2^PWM_BITS cycles.
- `RAMP_DIV`, default 195_313: `sys_clk` cycles per ramp step. Must be ≥ 1.
- `MAX_DUTY`, default 256: duty value for a fully lit LED. Range 1..2^PWM_BITS. A value of 2^PWM_BITS means constantly on.

Ports:
- `sys_clk`, input, 1 bit: the single clock for the block.
- `rst_n`, input, 1 bit: reset, asynchronous and active-low. It is the only reset.
- `led_in`, input, 4 bits: requested LED pattern, synchronous to `sys_clk`. Bit i = 1 requests channel i on.
- `en`, input, 1 bit: output enable. When 0, all `led_out` bits are forced to 0.
- `led_out`, output, 4 bits: registered PWM drive to the LED pins.
- `busy`, output, 1 bit: high while any channel is still ramping.

## Operation
- **Target register.** `target[3:0]` registers `led_in` on every cycle. Channel i's goal is MAX_DUTY when `target[i]=1`, otherwise 0.
- **PWM counter.** `pwm_cnt` is PWM_BITS wide, free-running, and wraps from 2^PWM_BITS−1 to 0.
- **Ramp prescaler.**
  - `ramp_cnt` counts from 0 to RAMP_DIV−1 and then wraps to 0.
  - `tick` is high on the cycle where `ramp_cnt` = RAMP_DIV−1.
  - With RAMP_DIV=1, `tick` is high on every cycle.
- **Per-channel duty.** `duty[i]` is PWM_BITS+1 bits wide, unsigned. On each `tick`:
  - If `duty[i]` < goal, it increments by 1.
  - If `duty[i]` > goal, it decrements by 1.
  - If equal, it holds.
  - It never overshoots. It saturates at 0 and at MAX_DUTY.
- **Channel states.** These are derived from the registers; no separate FSM register is stored.
  - OFF: duty = 0 and goal = 0.
  - RISING: duty < goal.
  - ON: duty = MAX_DUTY and goal = MAX_DUTY.
  - FALLING: duty > goal.
  - OFF→RISING when `target[i]` goes to 1. RISING→ON when duty reaches MAX_DUTY.
  - ON→FALLING when `target[i]` goes to 0. FALLING→OFF when duty reaches 0.
  - RISING↔FALLING immediately on a target reversal. The ramp continues from the current duty with no jump.
- **Output compare.** Next `led_out[i]` = `en` AND (`pwm_cnt` < `eff[i]`), compared unsigned.
  - Without gamma, `eff[i]` = `duty[i]`.
- **Busy.** `busy` = OR over i of (`duty[i]` ≠ goal[i]). It is decoded from registers, with no added latency.
- **Enable.** `en` = 0 affects only `led_out`. The counters, duties and `busy` keep running, so re-enabling resumes at the current brightness.

## Timing
- **Reset.** Asynchronous assertion clears `pwm_cnt`, `ramp_cnt`, `duty`, `target` and `led_out` to 0, so `busy` = 0. Reset asserted mid-ramp abandons the ramp. Release is synchronous: the first active edge after `rst_n` rises is counted as cycle 0.
- **Input to target.** A `led_in` change at edge N is in `target` at edge N+1.
- **Tick coincident with target change.** A `tick` on the same edge as a `target` update uses the old `target` value.
- **Duty to output.** A duty change at edge M is reflected in `led_out` from edge M+1.
- **`en` to output.** One cycle of latency, because `led_out` is registered.
- **Full-scale ramp time.** MAX_DUTY × RAMP_DIV cycles. With the defaults this is about 1.0 s at 50 MHz.
- **PWM duty cycle.** `led_out[i]` is high for exactly `eff[i]` of every 2^PWM_BITS cycles. `eff` = 0 means never high; `eff` = 2^PWM_BITS means always high.

## Configuration
- Macro: `LED_PWM_FADER_GAMMA_EN`.
- **Defined:** `eff[i]` = (`duty[i]` × `duty[i]`) >> PWM_BITS. The product uses a 2·(PWM_BITS+1)-bit intermediate, and the result is truncated to PWM_BITS+1 bits. This gives a perceptually linear fade.
- **Undefined:** `eff[i]` = `duty[i]` (linear). No multiplier is instantiated.
- All other behaviour is identical in both builds, including ramp timing, `busy` and reset.

## Test plan
All scenarios use PWM_BITS=4, RAMP_DIV=4, MAX_DUTY=16 unless stated otherwise.
1. **Reset.** Hold `rst_n`=0 with `led_in`=4'hF and `en`=1 → `led_out`=0 and `busy`=0 throughout. Release → `busy`=1 from the cycle after `target` updates.
2. **Full rise.** Set `led_in`=4'b0001 and hold → duty[0] increments every 4 cycles and reaches 16 after 64 cycles; `busy` falls on that edge. Afterwards `led_out[0]`=1 continuously and `led_out[3:1]`=0.
3. **Mid-ramp reversal.** Drop `led_in[0]` to 0 when duty[0]=9 → duty goes 9→8→…→0 with one step per tick and no jump. In steady state, `led_out[0]` is high for exactly duty[0] of every 16 cycles.
4. **Enable gating.** With ch0 ON, deassert `en` → `led_out`=0 from the next edge while `busy` is unaffected. Reassert `en` → full brightness again one cycle later.
5. **Reset mid-ramp.** With duty[1]=7 and rising, pulse `rst_n` low → duty[1]=0 and `led_out`=0 immediately. After release with `led_in[1]` still 1, the ramp restarts from 0.
6. **Gamma build** (`LED_PWM_FADER_GAMMA_EN` defined). With duty[2]=8 → `eff`=4, so `led_out[2]` is high for 4 of every 16 cycles. With duty[2]=16 → always high.

Source files
------------

// File: rtl/led_pwm_fader_if.sv
// Pattern/enable inputs and PWM drive outputs of led_pwm_fader.
// Handshake: none. led_in and en are sampled every sys_clk edge, and led_out is registered.
// busy and ch_state are decoded from registers with no added latency.
interface led_pwm_fader_if;
  logic [3:0] led_in;
  logic       en;
  logic [3:0] led_out;
  logic       busy;
  logic [7:0] ch_state;  // 2 bits per channel: 0 OFF, 1 RISING, 2 ON, 3 FALLING

  modport master (output led_in, output en, input led_out, input busy, input ch_state);
  modport slave  (input led_in, input en, output led_out, output busy, output ch_state);
endinterface

// File: rtl/led_pwm_fader.sv
// Four-channel LED PWM stage that turns on/off pattern edges into linear duty ramps.
// Optional quadratic brightness curve: define LED_PWM_FADER_GAMMA_EN.
module led_pwm_fader #(
  parameter int PWM_BITS = 8,
  parameter int RAMP_DIV = 195_313,
  parameter int MAX_DUTY = 256
) (
  input logic            sys_clk,
  input logic            rst_n,
  led_pwm_fader_if.slave bus
);
  localparam int DW = PWM_BITS + 1;
  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DW-1:0] DUTY_MAX  = DW'(MAX_DUTY);
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_DIV - 1);

  typedef enum logic [1:0] {
    CH_OFF     = 2'd0,
    CH_RISING  = 2'd1,
    CH_ON      = 2'd2,
    CH_FALLING = 2'd3
  } ch_state_t;

  logic [3:0]          target;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [RW-1:0]       ramp_cnt;
  logic [DW-1:0]       duty [4];
  logic [DW-1:0]       goal [4];
  logic [DW-1:0]       eff [4];
  logic [3:0]          ramping;
  logic [3:0]          led_out_q;
  ch_state_t           ch_state [4];
  logic                tick;

  assign tick = (ramp_cnt == RAMP_LAST);

  // Channel state is derived from duty/goal; there is no separate state register.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      goal[i]    = target[i] ? DUTY_MAX : '0;
      ramping[i] = (duty[i] != goal[i]);
      if (duty[i] < goal[i])      ch_state[i] = CH_RISING;
      else if (duty[i] > goal[i]) ch_state[i] = CH_FALLING;
      else if (goal[i] == '0)     ch_state[i] = CH_OFF;
      else                        ch_state[i] = CH_ON;
    end
  end

`ifdef LED_PWM_FADER_GAMMA_EN
  logic [2*DW-1:0] duty_sq [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      duty_sq[i] = (2*DW)'(duty[i]) * (2*DW)'(duty[i]);
      eff[i]     = DW'(duty_sq[i] >> PWM_BITS);
    end
  end
`else
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      eff[i] = duty[i];
    end
  end
`endif

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      target    <= '0;
      pwm_cnt   <= '0;
      ramp_cnt  <= '0;
      led_out_q <= '0;
      for (int i = 0; i < 4; i++) begin
        duty[i] <= '0;
      end
    end else begin
      target   <= bus.led_in;
      pwm_cnt  <= pwm_cnt + 1'b1;
      ramp_cnt <= tick ? '0 : ramp_cnt + 1'b1;
      for (int i = 0; i < 4; i++) begin
        // Goal is the registered target, so a tick on the target-update edge sees the old goal.
        if (tick) begin
          if (duty[i] < goal[i])      duty[i] <= duty[i] + 1'b1;
          else if (duty[i] > goal[i]) duty[i] <= duty[i] - 1'b1;
        end
        led_out_q[i] <= bus.en && ({1'b0, pwm_cnt} < eff[i]);
      end
    end
  end

  assign bus.led_out  = led_out_q;
  assign bus.busy     = |ramping;
  assign bus.ch_state = {ch_state[3], ch_state[2], ch_state[1], ch_state[0]};
endmodule

// File: tb/tb_led_pwm_fader.sv
// Directed bench for led_pwm_fader with PWM_BITS=4, RAMP_DIV=4, MAX_DUTY=16.
// Edge 0 is the first rising edge after reset release; values are sampled on the falling edge.
module tb_led_pwm_fader;
  localparam int PWM_BITS = 4;
  localparam int RAMP_DIV = 4;
  localparam int MAX_DUTY = 16;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  led_pwm_fader_if bus ();

  led_pwm_fader #(
    .PWM_BITS(PWM_BITS),
    .RAMP_DIV(RAMP_DIV),
    .MAX_DUTY(MAX_DUTY)
  ) dut (
    .sys_clk(sys_clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Duty after edge k. Scenario 3 drops the target after edge 35 (duty 9).
  function automatic int duty_model(input int sc, input int k);
    int d;
    if (sc == 3 && k >= 39) begin
      d = 9 - (k - 35) / 4;
      if (d < 0) d = 0;
    end else begin
      d = (k + 1) / 4;
      if (d > MAX_DUTY) d = MAX_DUTY;
    end
    return d;
  endfunction

  function automatic int goal_model(input int sc, input int k);
    return (sc == 3 && k >= 36) ? 0 : MAX_DUTY;
  endfunction

  function automatic int eff_model(input int d);
`ifdef LED_PWM_FADER_GAMMA_EN
    return (d * d) / 16;
`else
    return d;
`endif
  endfunction

  function automatic int state_model(input int d, input int g);
    if (d < g) return 1;
    if (d > g) return 3;
    if (g == 0) return 0;
    return 2;
  endfunction

  task automatic do_reset(input logic [3:0] led, input logic en);
    @(negedge sys_clk);
    rst_n      = 1'b0;
    bus.led_in = led;
    bus.en     = en;
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
  endtask

  // Run edges 0..k_end checking one active channel cycle by cycle.
  task automatic run_window(input string tag, input int sc, input int ch,
                            input int k_end, input int en_from);
    logic [3:0]  exp_led;
    logic [31:0] exp_st;
    int d, dp, g;
    for (int k = 0; k <= k_end; k++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      d  = duty_model(sc, k);
      dp = duty_model(sc, k - 1);
      g  = goal_model(sc, k);
      exp_led     = '0;
      exp_led[ch] = (k >= en_from) && ((k % 16) < eff_model(dp));
      exp_st      = 32'(state_model(d, g)) << (2 * ch);
      check({tag, "_led"},   32'(bus.led_out),  32'(exp_led));
      check({tag, "_busy"},  32'(bus.busy),     32'(d != g));
      check({tag, "_state"}, 32'(bus.ch_state), exp_st);
      if (sc == 3 && k == 35) bus.led_in = 4'b0000;
      if (k + 1 == en_from) bus.en = 1'b1;
    end
  endtask

  initial begin
    bus.led_in = 4'hF;
    bus.en     = 1'b1;
    #1 rst_n = 1'b0;

    // Reset holds outputs low even with all channels requested.
    repeat (3) begin
      @(negedge sys_clk);
      check("rst_led",   32'(bus.led_out),  32'h0);
      check("rst_busy",  32'(bus.busy),     32'h0);
      check("rst_state", 32'(bus.ch_state), 32'h0);
    end
    rst_n = 1'b1;
    #1 check("rel_busy0", 32'(bus.busy), 32'h0);
    @(posedge sys_clk);
    @(negedge sys_clk);
    check("rel_busy1",  32'(bus.busy),     32'h1);
    check("rel_state1", 32'(bus.ch_state), 32'h55);
    check("rel_led1",   32'(bus.led_out),  32'h0);

    // Full rise of channel 0, then steady full brightness.
    do_reset(4'b0001, 1'b1);
    run_window("rise", 2, 0, 80, 0);

    // Reversal at duty 9 ramps back down to 0.
    do_reset(4'b0001, 1'b1);
    run_window("rev", 3, 0, 90, 0);

    // Enable held low during early ramp, then gating in the ON state.
    do_reset(4'b0001, 1'b0);
    run_window("en", 4, 0, 70, 11);
    bus.en = 1'b0;
    repeat (5) begin
      @(negedge sys_clk);
      check("en_off_led",   32'(bus.led_out),  32'h0);
      check("en_off_busy",  32'(bus.busy),     32'h0);
      check("en_off_state", 32'(bus.ch_state), 32'h2);
    end
    bus.en = 1'b1;
    repeat (2) begin
      @(negedge sys_clk);
      check("en_on_led", 32'(bus.led_out), 32'h1);
    end

    // Reset in the middle of channel 1's rise, then a fresh ramp.
    do_reset(4'b0010, 1'b1);
    run_window("mid", 2, 1, 28, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_led",   32'(bus.led_out),  32'h0);
    check("midrst_busy",  32'(bus.busy),     32'h0);
    check("midrst_state", 32'(bus.ch_state), 32'h0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    run_window("restart", 2, 1, 40, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
